// File: rtl/hms_seg_scanner_pkg.sv
// Shared constants for the hh:mm:ss seven-segment scanner: segment layout,
// digit codes (a..g only, dp handled separately) and scan geometry.
package hms_seg_scanner_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int NUM_POS    = 8;
   localparam int BCD_W      = 4;

   // Bit positions inside the 8-bit seg_data word {a,b,c,d,e,f,g,dp}
   localparam int SEG_A_BIT  = 7;
   localparam int SEG_B_BIT  = 6;
   localparam int SEG_C_BIT  = 5;
   localparam int SEG_D_BIT  = 4;
   localparam int SEG_E_BIT  = 3;
   localparam int SEG_F_BIT  = 2;
   localparam int SEG_G_BIT  = 1;
   localparam int SEG_DP_BIT = 0;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_DASH  = 8'h02;
   localparam logic [7:0] COM_OFF   = 8'hFF;
   localparam logic [7:0] COM_FIRST = 8'h80;

   // 7-bit a..g patterns, i.e. the 8-bit codes FC,60,DA,... without dp
   localparam logic [6:0] SEG7_0    = 7'h7E;
   localparam logic [6:0] SEG7_1    = 7'h30;
   localparam logic [6:0] SEG7_2    = 7'h6D;
   localparam logic [6:0] SEG7_3    = 7'h79;
   localparam logic [6:0] SEG7_4    = 7'h33;
   localparam logic [6:0] SEG7_5    = 7'h5B;
   localparam logic [6:0] SEG7_6    = 7'h5F;
   localparam logic [6:0] SEG7_7    = 7'h70;
   localparam logic [6:0] SEG7_8    = 7'h7F;
   localparam logic [6:0] SEG7_9    = 7'h7B;
   localparam logic [6:0] SEG7_DASH = 7'h01;

   typedef logic [BCD_W-1:0] bcd_t;
   typedef logic [2:0]       scan_idx_t;

   localparam scan_idx_t SCAN_FIRST = 3'd0;
   localparam scan_idx_t SCAN_LAST  = 3'd5;

endpackage

// File: rtl/hms_seg_scanner_if.sv
// Display-side bundle between the clock counters (master) and the segment
// scanner (slave).
interface hms_seg_scanner_if;
   import hms_seg_scanner_pkg::*;

   logic [BCD_W*NUM_DIGITS-1:0] digits_bcd;
   logic [NUM_DIGITS-1:0]       dp_mask;
   logic [NUM_DIGITS-1:0]       blink_mask;
   logic                        lz_blank;
   logic [NUM_POS-1:0]          seg_com;
   logic [7:0]                  seg_data;
   logic                        frame_start;

   modport master (
      output digits_bcd, dp_mask, blink_mask, lz_blank,
      input  seg_com, seg_data, frame_start
   );

   modport slave (
      input  digits_bcd, dp_mask, blink_mask, lz_blank,
      output seg_com, seg_data, frame_start
   );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to a..g decoder; codes 10-15 render as a dash.
module bcd_to_seg7
   import hms_seg_scanner_pkg::*;
(
   input  bcd_t       bcd,
   output logic [6:0] seg
);

   // Digit lookup
   always_comb begin
      seg = SEG7_DASH;
      case (bcd)
         4'd0:    seg = SEG7_0;
         4'd1:    seg = SEG7_1;
         4'd2:    seg = SEG7_2;
         4'd3:    seg = SEG7_3;
         4'd4:    seg = SEG7_4;
         4'd5:    seg = SEG7_5;
         4'd6:    seg = SEG7_6;
         4'd7:    seg = SEG7_7;
         4'd8:    seg = SEG7_8;
         4'd9:    seg = SEG7_9;
         default: seg = SEG7_DASH;
      endcase
   end

endmodule

// File: rtl/hms_seg_scanner.sv
// Time-multiplexes a per-frame snapshot of six BCD digits onto an 8-position
// common-cathode bank, with leading-zero blanking and set-mode blinking.
module hms_seg_scanner
   import hms_seg_scanner_pkg::*;
#(
   parameter int SCAN_DIV     = 1,
   parameter int BLINK_FRAMES = 500
) (
   input  logic               clk,
   input  logic               rst,
   hms_seg_scanner_if.slave   bus
);

   localparam int PW = $clog2(SCAN_DIV) + 1;
   localparam int FW = $clog2(BLINK_FRAMES) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0]               presc_r;
   scan_idx_t                   scan_idx_r;
   logic [BCD_W*NUM_DIGITS-1:0] digits_snap_r;
   logic [NUM_DIGITS-1:0]       dp_snap_r;
   logic [FW-1:0]               frame_cnt_r;
   logic                        blink_phase_r;
   logic [NUM_POS-1:0]          seg_com_r;
   logic [7:0]                  seg_data_r;
   logic                        frame_start_r;

   logic                        tick_s;
   logic                        boundary_s;
   bcd_t                        digit_s;
   logic                        dp_s;
   logic                        blink_en_s;
   logic                        blank_s;
   logic [6:0]                  seg7_s;
   logic [NUM_POS-1:0]          seg_com_nxt_s;
   logic [7:0]                  seg_data_nxt_s;

   assign tick_s     = (presc_r == PRESC_LAST);
   assign boundary_s = tick_s && (scan_idx_r == SCAN_LAST);

   // Prescaler and scan position
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_r    <= {PW{1'b0}};
         scan_idx_r <= SCAN_FIRST;
      end else if (tick_s) begin
         presc_r    <= {PW{1'b0}};
         scan_idx_r <= (scan_idx_r == SCAN_LAST) ? SCAN_FIRST : scan_idx_r + 3'd1;
      end else begin
         presc_r    <= presc_r + PW'(1);
      end
   end

   // Frame snapshot and blink timebase; digits are only sampled at the frame boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_snap_r <= {(BCD_W*NUM_DIGITS){1'b0}};
         dp_snap_r     <= {NUM_DIGITS{1'b0}};
         frame_cnt_r   <= {FW{1'b0}};
         blink_phase_r <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         frame_start_r <= boundary_s;
         if (boundary_s) begin
            digits_snap_r <= bus.digits_bcd;
            dp_snap_r     <= bus.dp_mask;
            if (frame_cnt_r == FRAME_LAST) begin
               frame_cnt_r   <= {FW{1'b0}};
               blink_phase_r <= ~blink_phase_r;
            end else begin
               frame_cnt_r   <= frame_cnt_r + FW'(1);
            end
         end
      end
   end

   // Select the active digit; blink_mask is live, digit and dp come from the snapshot
   always_comb begin
      digit_s    = 4'd0;
      dp_s       = 1'b0;
      blink_en_s = 1'b0;
      case (scan_idx_r)
         3'd0: begin digit_s = digits_snap_r[3:0];   dp_s = dp_snap_r[0]; blink_en_s = bus.blink_mask[0]; end
         3'd1: begin digit_s = digits_snap_r[7:4];   dp_s = dp_snap_r[1]; blink_en_s = bus.blink_mask[1]; end
         3'd2: begin digit_s = digits_snap_r[11:8];  dp_s = dp_snap_r[2]; blink_en_s = bus.blink_mask[2]; end
         3'd3: begin digit_s = digits_snap_r[15:12]; dp_s = dp_snap_r[3]; blink_en_s = bus.blink_mask[3]; end
         3'd4: begin digit_s = digits_snap_r[19:16]; dp_s = dp_snap_r[4]; blink_en_s = bus.blink_mask[4]; end
         3'd5: begin digit_s = digits_snap_r[23:20]; dp_s = dp_snap_r[5]; blink_en_s = bus.blink_mask[5]; end
         default: begin digit_s = 4'd0; dp_s = 1'b0; blink_en_s = 1'b0; end
      endcase
   end

   bcd_to_seg7 u_dec (
      .bcd (digit_s),
      .seg (seg7_s)
   );

   // Pin values for the current position; blanking also kills the dp
   always_comb begin
      blank_s = (blink_phase_r && blink_en_s) ||
                (bus.lz_blank && (scan_idx_r == SCAN_LAST) && (digit_s == 4'd0));
      seg_com_nxt_s = ~(COM_FIRST >> scan_idx_r);
      if (blank_s) begin
         seg_data_nxt_s = SEG_BLANK;
      end else begin
         seg_data_nxt_s = {seg7_s, dp_s};
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_com_r  <= COM_OFF;
         seg_data_r <= SEG_BLANK;
      end else begin
         seg_com_r  <= seg_com_nxt_s;
         seg_data_r <= seg_data_nxt_s;
      end
   end

   assign bus.seg_com     = seg_com_r;
   assign bus.seg_data    = seg_data_r;
   assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_hms_seg_scanner.sv
// Directed bench for hms_seg_scanner: one instance at SCAN_DIV=1/BLINK_FRAMES=2,
// one at SCAN_DIV=3, outputs sampled on the falling edge.
module tb_hms_seg_scanner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   hms_seg_scanner_if ifa ();
   hms_seg_scanner_if ifb ();

   hms_seg_scanner #(.SCAN_DIV(1), .BLINK_FRAMES(2)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   hms_seg_scanner #(.SCAN_DIV(3), .BLINK_FRAMES(500)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   logic [7:0] com_exp [6]  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB};
   logic [7:0] d123456 [6]  = '{8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60};
   logic [7:0] d_dp [6]     = '{8'hBE, 8'hB6, 8'h67, 8'hF2, 8'hDA, 8'h60};
   logic [7:0] d_lz [6]     = '{8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h02, 8'h00};

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_a(input string tag, input logic [7:0] com, input logic [7:0] data, input logic fs);
      chk({tag, "_com"},  ifa.seg_com,  com);
      chk({tag, "_data"}, ifa.seg_data, data);
      chk({tag, "_fs"},   {7'd0, ifa.frame_start}, {7'd0, fs});
   endtask

   // Advance at least one cycle, then until frame_start is seen or the budget expires
   task automatic wait_fs(input bit use_b, input int budget);
      int  n = 0;
      logic fs;
      step();
      fs = use_b ? ifb.frame_start : ifa.frame_start;
      while (fs !== 1'b1 && n < budget) begin
         step();
         n++;
         fs = use_b ? ifb.frame_start : ifa.frame_start;
      end
      chk(use_b ? "fs_wait_b" : "fs_wait_a", {7'd0, fs}, 8'd1);
   endtask

   initial begin
      ifa.digits_bcd = 24'h987654; ifa.dp_mask = 6'h3F; ifa.blink_mask = 6'h3F; ifa.lz_blank = 1'b1;
      ifb.digits_bcd = 24'h123456; ifb.dp_mask = 6'h00; ifb.blink_mask = 6'h00; ifb.lz_blank = 1'b0;

      // Reset held for three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         chk_a($sformatf("rst%0d", i), 8'hFF, 8'h00, 1'b0);
         chk($sformatf("rst%0d_b_com", i), ifb.seg_com, 8'hFF);
      end

      // Basic scan of 123456
      ifa.digits_bcd = 24'h123456; ifa.dp_mask = 6'h00; ifa.blink_mask = 6'h00; ifa.lz_blank = 1'b0;
      rst = 1'b0;
      wait_fs(1'b0, 50);
      for (int k = 0; k < 12; k++) begin
         step();
         chk_a($sformatf("scan%0d", k), com_exp[k % 6], d123456[k % 6], (k % 6) == 5);
      end

      // Mid-frame change is held off until the next boundary
      step(); chk_a("mid0", 8'h7F, 8'hBE, 1'b0);
      step(); chk_a("mid1", 8'hBF, 8'hB6, 1'b0);
      ifa.digits_bcd = 24'h000000;
      for (int k = 2; k < 6; k++) begin
         step();
         chk_a($sformatf("mid%0d", k), com_exp[k], d123456[k], k == 5);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         chk_a($sformatf("zero%0d", k), com_exp[k], 8'hFC, k == 5);
      end

      // Decimal point on digit2
      ifa.digits_bcd = 24'h123456; ifa.dp_mask = 6'b000100;
      wait_fs(1'b0, 50);
      for (int k = 0; k < 6; k++) begin
         step();
         chk_a($sformatf("dp%0d", k), com_exp[k], d_dp[k], k == 5);
      end

      // Leading-zero blank and out-of-range BCD
      ifa.digits_bcd = 24'h0A2345; ifa.dp_mask = 6'h00; ifa.lz_blank = 1'b1;
      wait_fs(1'b0, 50);
      for (int k = 0; k < 6; k++) begin
         step();
         chk_a($sformatf("lz%0d", k), com_exp[k], d_lz[k], k == 5);
      end

      // Reset pulse while scan position is 3
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1;
      ifa.lz_blank = 1'b0; ifa.digits_bcd = 24'h123456; ifa.blink_mask = 6'b000011;
      step();
      chk_a("rstmid", 8'hFF, 8'h00, 1'b0);
      rst = 1'b0;
      step();
      chk_a("restart", 8'h7F, 8'hFC, 1'b0);

      // Blink: frames 2 and 3 blank digits 0 and 1
      for (int f = 0; f < 6; f++) begin
         for (int d = 0; d < 6; d++) begin
            logic [7:0] de;
            if (f == 0 && d == 0) continue;
            step();
            if (f == 0)                          de = 8'hFC;
            else if ((f == 2 || f == 3) && d < 2) de = 8'h00;
            else                                 de = d123456[d];
            chk_a($sformatf("blink_f%0d_d%0d", f, d), com_exp[d], de, d == 5);
         end
      end

      // SCAN_DIV=3 instance: each position held three cycles
      wait_fs(1'b1, 100);
      for (int k = 0; k < 36; k++) begin
         step();
         chk($sformatf("div3_%0d_com", k),  ifb.seg_com,  com_exp[(k / 3) % 6]);
         chk($sformatf("div3_%0d_data", k), ifb.seg_data, d123456[(k / 3) % 6]);
         chk($sformatf("div3_%0d_fs", k), {7'd0, ifb.frame_start}, {7'd0, ((k % 18) == 17)});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
